// File: rtl/cpu_defs_pkg.sv
// Shared pipeline-control definitions: register numbers, MD latencies,
// exception entry point and the per-source data-hazard test.
package cpu_defs_pkg;

    localparam logic [1:0]  TUSE_NEVER      = 2'd3;
    localparam logic [4:0]  EPC_REG         = 5'd14;
    localparam int          MULT_CYCLES_DEF = 5;
    localparam int          DIV_CYCLES_DEF  = 10;
    localparam int          CNT_W_DEF       = 4;
    localparam logic [31:0] EXC_ENTRY       = 32'h0000_4180;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A producer blocks a consumer when it writes the same non-zero register
    // and its result arrives later than the consumer needs it.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst,
        input logic       we,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && we && (dst == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_countdown.sv
// Multiply/divide busy countdown: loaded when an MD op launches in E,
// then counts down to zero. md_busy follows the registered count.
module md_countdown
    import cpu_defs_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic             md_is_div,
    input  logic             exc_req,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt
);

    md_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] ld_val;

    assign ld_val  = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    assign md_busy = (md_cnt != '0);

    // State and count registers; synchronous reset clears any countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_nx;
            md_cnt <= cnt_nx;
        end
    end

    // Next state: a squashed launch (exc_req) never loads; an exception
    // arriving mid-count lets the already-issued HI/LO op finish.
    always_comb begin
        state_nx = state;
        cnt_nx   = md_cnt;
        case (state)
            MD_IDLE: begin
                if (md_start && !exc_req) begin
                    cnt_nx   = ld_val;
                    state_nx = (ld_val != '0) ? MD_BUSY : MD_IDLE;
                end
            end
            MD_BUSY: begin
                cnt_nx   = (md_cnt != '0) ? md_cnt - 1'b1 : '0;
                state_nx = (cnt_nx == '0) ? MD_IDLE : MD_BUSY;
            end
            default: begin
                state_nx = MD_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Combines data,
// MD-unit and eret/EPC hazards into one stall, with exception requests
// taking priority over every stall.
module pipe_hazard_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic [1:0]       d_tuse_rs,
    input  logic [1:0]       d_tuse_rt,
    input  logic             d_is_md,
    input  logic             d_eret,
    input  logic [4:0]       e_regaddr,
    input  logic             e_regwrite,
    input  logic [1:0]       e_tnew,
    input  logic [4:0]       m_regaddr,
    input  logic             m_regwrite,
    input  logic [1:0]       m_tnew,
    input  logic             e_mtc0_epc,
    input  logic             m_mtc0_epc,
    input  logic             md_start,
    input  logic             md_is_div,
    input  logic             exc_req,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             flush_de,
    output logic             req_all,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt
);

    logic hz, md_hz, er_hz, stall;

    md_countdown #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .exc_req   (exc_req),
        .md_busy   (md_busy),
        .md_cnt    (md_cnt)
    );

    // Hazard terms and priority; all controls are forced low while in reset.
    always_comb begin
        hz    = src_hazard(d_rs, d_tuse_rs, e_regaddr, e_regwrite, e_tnew) |
                src_hazard(d_rs, d_tuse_rs, m_regaddr, m_regwrite, m_tnew) |
                src_hazard(d_rt, d_tuse_rt, e_regaddr, e_regwrite, e_tnew) |
                src_hazard(d_rt, d_tuse_rt, m_regaddr, m_regwrite, m_tnew);
        md_hz = d_is_md & (md_busy | md_start);
        er_hz = d_eret & (e_mtc0_epc | m_mtc0_epc);
        stall = hz | md_hz | er_hz;

        req_all  = exc_req & ~reset;
        stall_pc = stall & ~exc_req & ~reset;
        stall_fd = stall_pc;
        flush_de = stall_pc;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized cycles
// checked against a behavioural model of the hazard rules and MD latency.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_regaddr, m_regaddr;
    logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic       d_is_md, d_eret, e_regwrite, m_regwrite;
    logic       e_mtc0_epc, m_mtc0_epc, md_start, md_is_div, exc_req;
    logic       stall_pc, stall_fd, flush_de, req_all, md_busy;
    logic [3:0] md_cnt;

    int errors = 0;
    int checks = 0;
    int m_cnt  = 0;   // model of the MD countdown

    // {stall_pc, stall_fd, flush_de, req_all, md_busy, md_cnt}
    wire [8:0] obs = {stall_pc, stall_fd, flush_de, req_all, md_busy, md_cnt};

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_is_md(d_is_md), .d_eret(d_eret),
        .e_regaddr(e_regaddr), .e_regwrite(e_regwrite), .e_tnew(e_tnew),
        .m_regaddr(m_regaddr), .m_regwrite(m_regwrite), .m_tnew(m_tnew),
        .e_mtc0_epc(e_mtc0_epc), .m_mtc0_epc(m_mtc0_epc),
        .md_start(md_start), .md_is_div(md_is_div), .exc_req(exc_req),
        .stall_pc(stall_pc), .stall_fd(stall_fd), .flush_de(flush_de),
        .req_all(req_all), .md_busy(md_busy), .md_cnt(md_cnt)
    );

    // Expected outputs for the current inputs, from the hazard rules.
    function automatic logic [8:0] model_out();
        int  src [2];
        int  tu  [2];
        bit  hzd;
        bit  st;
        bit  rq;
        src[0] = d_rs;       src[1] = d_rt;
        tu[0]  = d_tuse_rs;  tu[1]  = d_tuse_rt;
        hzd = 0;
        for (int i = 0; i < 2; i++) begin
            if (src[i] != 0) begin
                if (e_regwrite && e_regaddr == src[i] && tu[i] < e_tnew) hzd = 1;
                if (m_regwrite && m_regaddr == src[i] && tu[i] < m_tnew) hzd = 1;
            end
        end
        if (d_is_md && (m_cnt != 0 || md_start)) hzd = 1;
        if (d_eret && (e_mtc0_epc || m_mtc0_epc)) hzd = 1;
        rq = exc_req && !reset;
        st = hzd && !exc_req && !reset;
        return {st, st, st, rq, (m_cnt != 0), 4'(m_cnt)};
    endfunction

    // Advance the model with the inputs present at this edge, then clock.
    task automatic tick();
        if (reset)                         m_cnt = 0;
        else if (m_cnt > 0)                m_cnt = m_cnt - 1;
        else if (md_start && !exc_req)     m_cnt = md_is_div ? 10 : 5;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0;
        d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_is_md = 0; d_eret = 0;
        e_regaddr = 0; e_regwrite = 0; e_tnew = 0;
        m_regaddr = 0; m_regwrite = 0; m_tnew = 0;
        e_mtc0_epc = 0; m_mtc0_epc = 0;
        md_start = 0; md_is_div = 0; exc_req = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        // hazards and an exception request present, still in reset
        d_rs = 5'd8; d_tuse_rs = 2'd0; e_regaddr = 5'd8; e_regwrite = 1; e_tnew = 2'd2;
        exc_req = 1; d_is_md = 1; md_start = 1;
        #1;
        checks++;
        if (obs !== 9'h000) begin
            errors++; $display("FAIL reset_outputs got=%h want=%h", obs, 9'h000);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (obs !== 9'h000) begin
            errors++; $display("FAIL reset_release got=%h want=%h", obs, 9'h000);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        d_rs = 5'd8; d_tuse_rs = 2'd1;
        e_regaddr = 5'd8; e_regwrite = 1; e_tnew = 2'd2;
        #1;
        checks++;
        if (obs !== 9'b111_0_0_0000) begin
            errors++; $display("FAIL load_use_e got=%b want=%b", obs, 9'b111000000);
        end
        tick();
        e_regwrite = 0; e_regaddr = 0; e_tnew = 0;
        m_regaddr = 5'd8; m_regwrite = 1; m_tnew = 2'd1;
        #1;
        checks++;
        if (obs !== 9'h000) begin
            errors++; $display("FAIL load_use_m got=%b want=%b", obs, 9'h000);
        end
        // same check on the rt path
        idle_inputs();
        d_rt = 5'd9; d_tuse_rt = 2'd0; m_regaddr = 5'd9; m_regwrite = 1; m_tnew = 2'd1;
        #1;
        checks++;
        if (stall_fd !== 1'b1) begin
            errors++; $display("FAIL rt_hazard_m got=%b want=1", stall_fd);
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        d_rs = 5'd0; d_tuse_rs = 2'd0; d_rt = 5'd0; d_tuse_rt = 2'd0;
        e_regaddr = 5'd0; e_regwrite = 1; e_tnew = 2'd2;
        m_regaddr = 5'd0; m_regwrite = 1; m_tnew = 2'd2;
        #1;
        checks++;
        if (obs !== 9'h000) begin
            errors++; $display("FAIL zero_reg got=%b want=%b", obs, 9'h000);
        end
    endtask

    task automatic test_div_countdown();
        idle_inputs();
        md_start = 1; md_is_div = 1;
        tick();
        md_start = 0; md_is_div = 0; d_is_md = 1;   // mflo waiting in D
        for (int k = 1; k <= 10; k++) begin
            #1;
            checks++;
            if (obs !== {5'b111_0_1, 4'(11 - k)}) begin
                errors++; $display("FAIL div_busy_%0d got=%b want=%b", k, obs, {5'b11101, 4'(11 - k)});
            end
            tick();
        end
        #1;
        checks++;
        if (obs !== 9'h000) begin
            errors++; $display("FAIL div_done got=%b want=%b", obs, 9'h000);
        end
    endtask

    task automatic test_eret();
        idle_inputs();
        d_eret = 1; e_mtc0_epc = 1;
        #1;
        checks++;
        if (stall_pc !== 1'b1) begin
            errors++; $display("FAIL eret_e got=%b want=1", stall_pc);
        end
        tick();
        e_mtc0_epc = 0; m_mtc0_epc = 1;
        #1;
        checks++;
        if (stall_pc !== 1'b1) begin
            errors++; $display("FAIL eret_m got=%b want=1", stall_pc);
        end
        tick();
        m_mtc0_epc = 0;
        #1;
        checks++;
        if (stall_pc !== 1'b0) begin
            errors++; $display("FAIL eret_clear got=%b want=0", stall_pc);
        end
    endtask

    task automatic test_exc_priority();
        idle_inputs();
        d_rs = 5'd8; d_tuse_rs = 2'd1; e_regaddr = 5'd8; e_regwrite = 1; e_tnew = 2'd2;
        exc_req = 1; md_start = 1; md_is_div = 0;
        #1;
        checks++;
        if (obs !== 9'b000_1_0_0000) begin
            errors++; $display("FAIL exc_priority got=%b want=%b", obs, 9'b000100000);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (md_cnt !== 4'd0) begin
            errors++; $display("FAIL exc_squash_md got=%0d want=0", md_cnt);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        md_start = 1;
        tick();
        md_start = 0;
        tick();
        tick();
        #1;
        checks++;
        if (md_cnt !== 4'd3) begin
            errors++; $display("FAIL mult_cnt3 got=%0d want=3", md_cnt);
        end
        reset = 1; d_is_md = 1; exc_req = 1;
        #1;
        checks++;
        if (obs[8:5] !== 4'b0000) begin
            errors++; $display("FAIL reset_comb got=%b want=0000", obs[8:5]);
        end
        tick();
        #1;
        checks++;
        if (obs !== 9'h000) begin
            errors++; $display("FAIL reset_mid got=%b want=%b", obs, 9'h000);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            d_rs       = 5'($urandom_range(0, 3));
            d_rt       = 5'($urandom_range(0, 3));
            d_tuse_rs  = 2'($urandom_range(0, 3));
            d_tuse_rt  = 2'($urandom_range(0, 3));
            d_is_md    = ($urandom_range(0, 3) == 0);
            d_eret     = ($urandom_range(0, 5) == 0);
            e_regaddr  = 5'($urandom_range(0, 3));
            e_regwrite = 1'($urandom);
            e_tnew     = 2'($urandom_range(0, 3));
            m_regaddr  = 5'($urandom_range(0, 3));
            m_regwrite = 1'($urandom);
            m_tnew     = 2'($urandom_range(0, 3));
            e_mtc0_epc = ($urandom_range(0, 5) == 0);
            m_mtc0_epc = ($urandom_range(0, 5) == 0);
            md_start   = ($urandom_range(0, 7) == 0);
            md_is_div  = 1'($urandom);
            exc_req    = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (obs !== model_out()) begin
                errors++; $display("FAIL random_%0d got=%b want=%b", n, obs, model_out());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_div_countdown();
        test_eret();
        test_exc_priority();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
